// File: rtl/disp_sched.sv
// Display scheduler: shares the seven-digit display between a live source (A)
// and a one-shot message source (B), with blank gaps around each message.
// Optional feature macro: DISP_SCHED_BLINK_EN (blink the message while shown).
module disp_sched #(
    parameter int unsigned DWELL      = 100_000_000,
    parameter int unsigned GAP        = 4,
    parameter int unsigned CW         = 27,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [27:0] dig_a,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [27:0] dig_b,
    input  logic        abort,
    output logic [27:0] dig_out,
    output logic [6:0]  blank,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StShowA, StBlank1, StShowB, StBlank2} state_e;

    // A zero dwell still shows the message for one cycle.
    localparam int unsigned   DW       = (DWELL == 0) ? 1 : DWELL;
    localparam logic [CW-1:0] DWELL_M1 = CW'(DW - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'((GAP == 0) ? 0 : GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [27:0]   msg_q, msg_d;
    logic [27:0]   dig_d;
    logic [6:0]    blank_d;
    logic          ready_d, busy_d, done_d;

    // Digits 10..15 are never shown; they blank their position.
    function automatic logic [6:0] blank_of(input logic [27:0] d);
        logic [6:0] m;
        for (int i = 0; i < 7; i++) begin
            m[i] = (d[4*i +: 4] > 4'd9);
        end
        return m;
    endfunction

`ifdef DISP_SCHED_BLINK_EN
    localparam int unsigned   BH    = (BLINK_HALF == 0) ? 1 : BLINK_HALF;
    localparam logic [CW-1:0] BH_M1 = CW'(BH - 1);

    logic          phase_q, phase_d;
    logic [CW-1:0] bcnt_q, bcnt_d;

    // Blink phase and half-period counter; held at "visible" outside SHOW_B.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end
`else
    // BLINK_HALF has no effect without blink support.
    logic unused_blink_half;
    assign unused_blink_half = ^BLINK_HALF;
`endif

    // Scheduler state and registered display outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= StShowA;
            cnt_q   <= '0;
            msg_q   <= '0;
            dig_out <= '0;
            blank   <= 7'h7F;
            b_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            dig_out <= dig_d;
            blank   <= blank_d;
            b_ready <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        dig_d   = dig_out;
        blank_d = blank;
        ready_d = b_ready;
        done_d  = 1'b0;
`ifdef DISP_SCHED_BLINK_EN
        phase_d = 1'b0;
        bcnt_d  = BH_M1;
`endif
        unique case (state_q)
            StShowA: begin
                dig_d   = dig_a;
                blank_d = blank_of(dig_a);
                ready_d = 1'b1;
                if (b_valid && b_ready) begin
                    msg_d   = dig_b;
                    ready_d = 1'b0;
                    if (GAP == 0) begin
                        state_d = StShowB;
                        cnt_d   = DWELL_M1;
                        dig_d   = dig_b;
                        blank_d = blank_of(dig_b);
                    end else begin
                        state_d = StBlank1;
                        cnt_d   = GAP_M1;
                        blank_d = 7'h7F;
                    end
                end
            end
            StBlank1: begin
                blank_d = 7'h7F;
                if (cnt_q == '0) begin
                    state_d = StShowB;
                    cnt_d   = DWELL_M1;
                    dig_d   = msg_q;
                    blank_d = blank_of(msg_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShowB: begin
                dig_d   = msg_q;
                blank_d = blank_of(msg_q);
`ifdef DISP_SCHED_BLINK_EN
                phase_d = (bcnt_q == '0) ? ~phase_q : phase_q;
                bcnt_d  = (bcnt_q == '0) ? BH_M1 : bcnt_q - 1'b1;
                if (phase_d) blank_d = 7'h7F;
`endif
                if (cnt_q == '0) begin
                    if (GAP == 0) begin
                        state_d = StShowA;
                        dig_d   = dig_a;
                        blank_d = blank_of(dig_a);
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StBlank2;
                        cnt_d   = GAP_M1;
                        blank_d = 7'h7F;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StBlank2: begin
                blank_d = 7'h7F;
                if (cnt_q == '0) begin
                    state_d = StShowA;
                    dig_d   = dig_a;
                    blank_d = blank_of(dig_a);
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StShowA;
        endcase

        // Cancel wins over normal completion and never signals done.
        if (abort && state_q != StShowA) begin
            state_d = StShowA;
            dig_d   = dig_a;
            blank_d = blank_of(dig_a);
            ready_d = 1'b1;
            done_d  = 1'b0;
        end

        busy_d = (state_d != StShowA);
    end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: directed cases plus randomized traffic
// compared against a timeline model (offsets from the accept edge).
module tb_disp_sched;

    localparam int G = 2;
    localparam int D = 8;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN;
    logic [27:0] dig_a, dig_b, dig_out;
    logic        b_valid, b_ready, abort, busy, done;
    logic [6:0]  blank;

    int n_checks = 0;
    int n_errors = 0;

    disp_sched #(.DWELL(D), .GAP(G), .CW(27), .BLINK_HALF(2)) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .dig_a     (dig_a),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .dig_b     (dig_b),
        .abort     (abort),
        .dig_out   (dig_out),
        .blank     (blank),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Model: message timeline measured in edges since acceptance.
    bit          m_active, m_rdy, m_busy, m_done, m_known, m_acc;
    int          m_k;
    logic [27:0] m_msg, m_dig;
    logic [6:0]  m_blank;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] blank_ref(input logic [27:0] d);
        logic [6:0] m = '0;
        for (int i = 0; i < 7; i++) m[i] = (((d >> (4 * i)) & 28'hF) > 9);
        return m;
    endfunction

    task automatic model_reset();
        m_active = 0; m_rdy = 0; m_busy = 0; m_done = 0;
        m_known = 1; m_dig = '0; m_blank = 7'h7F; m_k = 0;
    endtask

    task automatic model_edge(input logic [27:0] a, input bit v, input logic [27:0] b,
                              input bit ab);
        m_done = 0;
        m_acc  = 0;
        if (!m_active) begin
            if (v && m_rdy) begin
                m_active = 1; m_k = 0; m_msg = b; m_acc = 1;
            end
        end else if (ab) begin
            m_active = 0;
        end else begin
            m_k++;
            if (m_k == 2 * G + D) begin
                m_active = 0; m_done = 1;
            end
        end
        m_rdy  = !m_active;
        m_busy = m_active;
        if (!m_active) begin
            m_known = 1; m_dig = a; m_blank = blank_ref(a);
        end else if (m_k < G) begin
            m_known = 0; m_blank = 7'h7F;
        end else if (m_k < G + D) begin
            m_known = 1; m_dig = m_msg; m_blank = blank_ref(m_msg);
        end else begin
            m_known = 1; m_dig = m_msg; m_blank = 7'h7F;
        end
    endtask

    task automatic check_outputs();
        check_eq("b_ready", 32'(b_ready), 32'(m_rdy));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("blank", 32'(blank), 32'(m_blank));
        if (m_known) check_eq("dig_out", 32'(dig_out), 32'(m_dig));
    endtask

    // One clock: drive at the falling edge, update model on rise, check at next fall.
    task automatic step(input logic [27:0] a, input bit v, input logic [27:0] b, input bit ab);
        dig_a = a; b_valid = v; dig_b = b; abort = ab;
        @(posedge CLK100MHZ);
        model_edge(a, v, b, ab);
        @(negedge CLK100MHZ);
        check_outputs();
    endtask

    function automatic logic [27:0] rand_digits();
        logic [27:0] d = '0;
        for (int i = 0; i < 7; i++) d = d | (28'($urandom_range(0, 15)) << (4 * i));
        return d;
    endfunction

    initial begin
        bit          v;
        logic [27:0] b, a;
        int          acc_cnt;
        int          acc_first;

        CPU_RESETN = 1'b0;
        dig_a = '0; dig_b = '0; b_valid = 0; abort = 0;
        model_reset();
        repeat (2) @(negedge CLK100MHZ);
        check_outputs();
        CPU_RESETN = 1'b1;

        // Basic pass-through and digit blanking.
        step(28'h0123456, 0, '0, 0);
        check_eq("passthru", 32'(dig_out), 32'h0123456);
        step(28'hF000009, 0, '0, 0);
        check_eq("blank_d6", 32'(blank), 32'h40);

        // One message with full timeline.
        step(28'h0123456, 1, 28'h1111111, 0);
        for (int i = 0; i < 14; i++) step(28'h0123456, 0, '0, 0);

        // Abort three cycles into SHOW_B.
        step(28'h0222222, 1, 28'h3333333, 0);
        while (m_k < G + 2) step(28'h0222222, 0, '0, 0);
        step(28'h0654321, 0, '0, 1);
        check_eq("abort_dig", 32'(dig_out), 32'h0654321);
        check_eq("abort_done", 32'(done), 32'h0);
        step(28'h0654321, 0, '0, 0);

        // Held valid: accepts must be 2G+D+1 edges apart, each with fresh data.
        acc_cnt = 0; acc_first = -1;
        for (int i = 0; i < 40; i++) begin
            step(28'h0000777, 1, 28'(32'h0100000 + acc_cnt), 0);
            if (m_acc) begin
                if (acc_first >= 0) check_eq("accept_gap", 32'(i - acc_first), 32'(2 * G + D + 1));
                acc_first = i;
                acc_cnt++;
            end
        end

        // Asynchronous reset in the middle of SHOW_B.
        step(28'h0000001, 0, '0, 0);
        step(28'h0000001, 1, 28'h0987654, 0);
        while (m_k < G + 3) step(28'h0000001, 0, '0, 0);
        #1 CPU_RESETN = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK100MHZ);
        check_outputs();
        CPU_RESETN = 1'b1;

        // Randomized traffic with a source that holds valid until accepted.
        v = 0; b = rand_digits();
        for (int i = 0; i < 800; i++) begin
            if (!v) begin
                v = ($urandom_range(0, 3) == 0);
                b = rand_digits();
            end
            a = ($urandom_range(0, 1) == 0) ? rand_digits() : dig_a;
            step(a, v, b, $urandom_range(0, 24) == 0);
            if (m_acc) v = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
